mem_access_unit: RTL and testbench

Memory-stage load/store unit that sits directly downstream of the ALU. It takes the ALU result as an effective address, plus the rt operand as store data. It drives a variable-latency word-wide data bus and returns load data that is lane-extracted and sign- or zero-extended for writeback. A result/stall handshake lets the core hold while the bus is busy.

---
 rtl/mips_mem_pkg.sv | 58 +++++
 rtl/mem_access_unit_if.sv | 21 ++
 rtl/mem_access_unit_load_extract.sv | 34 +++
 rtl/mem_access_unit.sv | 153 +++++++++++++++
 tb/tb_mem_access_unit.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/mips_mem_pkg.sv
// Shared definitions for the memory-stage load/store unit: access size
// encodings, FSM state type, counter sizing and lane helper functions.
package mips_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUS  = 2'b01,
    DONE = 2'b10
  } state_t;

  // Bits needed to hold 0..timeout; never narrower than one bit.
  function automatic int cnt_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Low address bits as the access will use them: halves ignore bit 0,
  // words (and the unused encoding) ignore both bits.
  function automatic logic [1:0] align_lo(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return lo;
      SZ_HALF: return {lo[1], 1'b0};
      default: return 2'b00;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return lo[0];
      default: return (lo != 2'b00);
    endcase
  endfunction

  // Little-endian byte enables for an already-aligned low address.
  function automatic logic [3:0] byte_enables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: return 4'b0001 << lo;
      SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  // Store data replicated across all lanes so the byte enables alone pick it.
  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] data);
    case (size)
      SZ_BYTE: return {4{data[7:0]}};
      SZ_HALF: return {2{data[15:0]}};
      default: return data;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Word-wide variable-latency data bus between the load/store unit (master)
// and the memory system (slave).
interface mem_access_unit_if;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_ack;

  modport master (
    output bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    input  bus_rdata, bus_ack
  );

  modport slave (
    input  bus_req, bus_we, bus_addr, bus_be, bus_wdata,
    output bus_rdata, bus_ack
  );
endinterface

// File: rtl/mem_access_unit_load_extract.sv
// Load lane select plus sign/zero extension of the returned bus word.
module load_extract
  import mips_mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  // Pick the addressed lane and extend it to a full register value.
  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    data   = rdata;
    lane_b = rdata[7:0];
    lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
    case (addr)
      2'd0:    lane_b = rdata[7:0];
      2'd1:    lane_b = rdata[15:8];
      2'd2:    lane_b = rdata[23:16];
      default: lane_b = rdata[31:24];
    endcase
    case (size)
      SZ_BYTE: data = uns ? {24'd0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: data = uns ? {16'd0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: registers one CPU access, runs it on the
// data bus with an optional ack timeout, and returns extended load data.
// Optional feature macro: MEM_MISALIGN_TRAP_EN -- when defined, misaligned
// half/word accesses fail immediately instead of being forced aligned.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_valid,
  output logic        cpu_ready,
  input  logic        cpu_we,
  input  logic [1:0]  cpu_size,
  input  logic        cpu_unsigned,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        resp_misalign,
  mem_access_unit_if.master bus
);

  localparam int            CW     = cnt_width(TIMEOUT);
  localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);

  state_t        state_q, state_d;
  logic          we_q;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [29:0]   word_q;
  logic [1:0]    lo_q;
  logic [3:0]    be_q;
  logic [31:0]   wdata_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [31:0]   ext_data;
  logic [1:0]    acc_lo;
  logic          misalign_req;
  logic          timed_out;

  assign acc_lo    = align_lo(cpu_size, cpu_addr[1:0]);
  assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_VAL);

`ifdef MEM_MISALIGN_TRAP_EN
  logic mis_q;
  assign misalign_req  = is_misaligned(cpu_size, cpu_addr[1:0]);
  assign resp_misalign = (state_q == DONE) && mis_q;
`else
  assign misalign_req  = 1'b0;
  assign resp_misalign = 1'b0;
`endif

  load_extract u_extract (
    .rdata (bus.bus_rdata),
    .addr  (lo_q),
    .size  (size_q),
    .uns   (uns_q),
    .data  (ext_data)
  );

  // State register; reset always lands in IDLE, abandoning any access.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and state-decoded handshake outputs.
  always_comb begin
    state_d    = state_q;
    cpu_ready  = 1'b0;
    bus.bus_req = 1'b0;
    resp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        cpu_ready = 1'b1;
        if (cpu_valid) state_d = misalign_req ? DONE : BUS;
      end
      BUS: begin
        bus.bus_req = 1'b1;
        // Ack takes priority over a timeout landing in the same cycle.
        if (bus.bus_ack || timed_out) state_d = DONE;
      end
      DONE: begin
        resp_valid = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Access capture on accept, wait counter and result capture during BUS.
  always_ff @(posedge clk) begin
    // NOTE: the datapath registers are reset too so every output reads 0 after reset.
    if (!rst_n) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      word_q  <= '0;
      lo_q    <= 2'b00;
      be_q    <= 4'b0000;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (cpu_valid) begin
          we_q    <= cpu_we;
          size_q  <= cpu_size;
          uns_q   <= cpu_unsigned;
          word_q  <= cpu_addr[31:2];
          lo_q    <= acc_lo;
          be_q    <= byte_enables(cpu_size, acc_lo);
          wdata_q <= replicate(cpu_size, cpu_wdata);
          cnt_q   <= '0;
          rdata_q <= '0;
          err_q   <= misalign_req;
`ifdef MEM_MISALIGN_TRAP_EN
          mis_q   <= misalign_req;
`endif
        end
        BUS: begin
          if (bus.bus_ack) begin
            rdata_q <= we_q ? 32'd0 : ext_data;
            err_q   <= 1'b0;
          end else if (timed_out) begin
            rdata_q <= 32'd0;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = {word_q, 2'b00};
  assign bus.bus_be    = be_q;
  assign bus.bus_wdata = wdata_q;
  assign resp_rdata    = (state_q == DONE) ? rdata_q : 32'd0;
  assign resp_err      = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit (TIMEOUT = 4). Stimulus
// pushes the expected response; a monitor pops it when resp_valid appears.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  localparam int TO = 4;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_valid, cpu_ready, cpu_we, cpu_unsigned;
  logic [1:0]  cpu_size;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        resp_valid, resp_err, resp_misalign;
  logic [31:0] resp_rdata;

  int   tests = 0;
  int   fails = 0;
  exp_t sb_q[$];
  exp_t mon_e;

  mem_access_unit_if bus_if ();

  mem_access_unit #(.TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cpu_valid     (cpu_valid),
    .cpu_ready     (cpu_ready),
    .cpu_we        (cpu_we),
    .cpu_size      (cpu_size),
    .cpu_unsigned  (cpu_unsigned),
    .cpu_addr      (cpu_addr),
    .cpu_wdata     (cpu_wdata),
    .resp_valid    (resp_valid),
    .resp_rdata    (resp_rdata),
    .resp_err      (resp_err),
    .resp_misalign (resp_misalign),
    .bus           (bus_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compare on every response, flag responses nobody expects.
  always @(negedge clk) begin
    if (rst_n) begin
      if (sb_q.size() > 0) begin
        if (resp_valid) begin
          mon_e = sb_q.pop_front();
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_err", {31'd0, resp_err}, {31'd0, mon_e.err});
          check("resp_misalign", {31'd0, resp_misalign}, {31'd0, mon_e.mis});
        end
      end else begin
        check("resp_spurious", {31'd0, resp_valid}, 32'd0);
      end
    end
  end

  // One access. ack_k = cycle (after accept) in which ack is driven, 0 = never.
  // bypass = access expected to skip the bus entirely.
  task automatic access(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_k, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_addr,
                        input logic chk_wdata, input logic [31:0] exp_wdata,
                        input logic [31:0] exp_rdata, input logic exp_err,
                        input logic exp_mis, input bit bypass);
    int   r;
    exp_t e;
    r = bypass ? 1 : ((ack_k > 0) ? ack_k + 1 : TO + 2);
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.mis   = exp_mis;
    @(negedge clk);
    check("cpu_ready_idle", {31'd0, cpu_ready}, 32'd1);
    sb_q.push_back(e);
    cpu_valid = 1'b1; cpu_we = we; cpu_size = size; cpu_unsigned = uns;
    cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    for (int k = 1; k <= r; k++) begin
      if (k < r) begin
        check("bus_req", {31'd0, bus_if.bus_req}, 32'd1);
        check("bus_we", {31'd0, bus_if.bus_we}, {31'd0, we});
        check("bus_addr", bus_if.bus_addr, exp_addr);
        check("bus_be", {28'd0, bus_if.bus_be}, {28'd0, exp_be});
        if (chk_wdata) check("bus_wdata", bus_if.bus_wdata, exp_wdata);
        bus_if.bus_ack   = (k == ack_k);
        bus_if.bus_rdata = rdata;
        @(negedge clk);
      end else begin
        bus_if.bus_ack = 1'b0;
        check("resp_valid_cycle", {31'd0, resp_valid}, 32'd1);
        check("bus_req_done", {31'd0, bus_if.bus_req}, 32'd0);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_size = SZ_WORD;
    cpu_unsigned = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    bus_if.bus_ack = 1'b0; bus_if.bus_rdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", {31'd0, cpu_ready}, 32'd1);
    check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_bus_req", {31'd0, bus_if.bus_req}, 32'd0);
    check("rst_bus_addr", bus_if.bus_addr, 32'd0);
    check("rst_bus_be", {28'd0, bus_if.bus_be}, 32'd0);
    check("rst_bus_wdata", bus_if.bus_wdata, 32'd0);
    check("rst_resp_rdata", resp_rdata, 32'd0);
    check("rst_resp_err", {31'd0, resp_err}, 32'd0);
    rst_n = 1'b1;

    //      we    size     uns   addr          wdata         ack rdata         be       bus_addr      cw    wdata_exp     rdata_exp     err   mis   byp
    access(1'b0, SZ_WORD, 1'b0, 32'h0000_1000, 32'h0,        1, 32'hDEAD_BEEF, 4'b1111, 32'h0000_1000, 1'b0, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 0);
    access(1'b0, SZ_BYTE, 1'b0, 32'h0000_1003, 32'h0,        2, 32'h8000_0000, 4'b1000, 32'h0000_1000, 1'b0, 32'h0,        32'hFFFF_FF80, 1'b0, 1'b0, 0);
    access(1'b0, SZ_BYTE, 1'b1, 32'h0000_1003, 32'h0,        1, 32'h8000_0000, 4'b1000, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_0080, 1'b0, 1'b0, 0);
    access(1'b1, SZ_HALF, 1'b0, 32'h0000_2002, 32'h1234_ABCD, 1, 32'hFFFF_FFFF, 4'b1100, 32'h0000_2000, 1'b1, 32'hABCD_ABCD, 32'h0,        1'b0, 1'b0, 0);
    access(1'b1, SZ_BYTE, 1'b0, 32'h0000_0011, 32'h0000_00A5, 3, 32'h0,       4'b0010, 32'h0000_0010, 1'b1, 32'hA5A5_A5A5, 32'h0,        1'b0, 1'b0, 0);
    access(1'b0, SZ_BYTE, 1'b0, 32'h0000_1001, 32'h0,        1, 32'h1234_5678, 4'b0010, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_0056, 1'b0, 1'b0, 0);
    access(1'b0, SZ_HALF, 1'b0, 32'h0000_1002, 32'h0,        1, 32'h8001_7FFF, 4'b1100, 32'h0000_1000, 1'b0, 32'h0,        32'hFFFF_8001, 1'b0, 1'b0, 0);
    access(1'b0, SZ_HALF, 1'b1, 32'h0000_1002, 32'h0,        1, 32'h8001_7FFF, 4'b1100, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_8001, 1'b0, 1'b0, 0);
    access(1'b0, SZ_HALF, 1'b0, 32'h0000_1000, 32'h0,        1, 32'h8001_7FFF, 4'b0011, 32'h0000_1000, 1'b0, 32'h0,        32'h0000_7FFF, 1'b0, 1'b0, 0);
    // Timeout with no ack, then ack on the final permitted cycle.
    access(1'b0, SZ_WORD, 1'b0, 32'h0000_5004, 32'h0,        0, 32'h1111_1111, 4'b1111, 32'h0000_5004, 1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 0);
    access(1'b0, SZ_WORD, 1'b0, 32'h0000_5004, 32'h0,   TO + 1, 32'h0BAD_F00D, 4'b1111, 32'h0000_5004, 1'b0, 32'h0,        32'h0BAD_F00D, 1'b0, 1'b0, 0);
    // Misaligned accesses.
`ifdef MEM_MISALIGN_TRAP_EN
    access(1'b0, SZ_WORD, 1'b0, 32'h0000_3002, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1);
    access(1'b0, SZ_HALF, 1'b0, 32'h0000_3001, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b1, 1);
`else
    access(1'b0, SZ_WORD, 1'b0, 32'h0000_3002, 32'h0,        1, 32'hCAFE_BABE, 4'b1111, 32'h0000_3000, 1'b0, 32'h0,        32'hCAFE_BABE, 1'b0, 1'b0, 0);
    access(1'b0, SZ_HALF, 1'b0, 32'h0000_3001, 32'h0,        2, 32'h0000_F00F, 4'b0011, 32'h0000_3000, 1'b0, 32'h0,        32'hFFFF_F00F, 1'b0, 1'b0, 0);
`endif

    // Reset while an ack is pending; a later ack must be ignored.
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_size = SZ_WORD; cpu_addr = 32'h0000_4000;
    @(posedge clk);
    @(negedge clk);
    cpu_valid = 1'b0;
    check("rstmid_bus_req_before", {31'd0, bus_if.bus_req}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("rstmid_bus_req_after", {31'd0, bus_if.bus_req}, 32'd0);
    check("rstmid_cpu_ready", {31'd0, cpu_ready}, 32'd1);
    rst_n = 1'b1;
    bus_if.bus_ack = 1'b1; bus_if.bus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    bus_if.bus_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("rstmid_no_resp", {31'd0, resp_valid}, 32'd0);
      check("rstmid_idle", {31'd0, cpu_ready}, 32'd1);
      @(negedge clk);
    end

    check("scoreboard_drained", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
